// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory arbiter and its helpers.
package dmem_pkg;

    localparam int DMEM_ADDR_W = 10;
    localparam int DMEM_DATA_W = 32;

    // Which requester owns the read whose data returns next cycle.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_e;

    // Byte address to word address; the low two bits and anything above the
    // memory depth are dropped, so addresses wrap modulo the memory size.
    function automatic logic [DMEM_ADDR_W-1:0] byte_to_word(input logic [31:0] addr);
        return addr[DMEM_ADDR_W+1:2];
    endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Counts consecutive denied cycles of a low-priority requester and forces it
// to win once the count reaches MAX_WAIT.
module dmem_starve_ctr #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic dma_req,
    input  logic dma_gnt,
    output logic force_dma
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    assign force_dma = (cnt_q == 4'(MAX_WAIT));

    // Next count: clear on grant or idle, otherwise count up and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (!dma_req || dma_gnt) begin
            cnt_d = 4'd0;
        end else if (cnt_q != 4'(MAX_WAIT)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    // Counter register, cleared asynchronously by the active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port synchronous data memory between the CPU memory
// stage (priority) and a DMA port, and routes read data back to its owner.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [31:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [31:0]       dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_gnt,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              force_dma;
    logic              gnt_cpu;
    logic              gnt_dma;
    logic [ADDR_W-1:0] cpu_word;
    logic [ADDR_W-1:0] dma_word;
    owner_e            owner_q;
    owner_e            owner_d;

    // Only the word-address bits reach the memory; the rest are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{cpu_addr[31:ADDR_W+2], cpu_addr[1:0],
                                dma_addr[31:ADDR_W+2], dma_addr[1:0]};

    generate
        if (ADDR_W == DMEM_ADDR_W) begin : g_pkg_map
            assign cpu_word = byte_to_word(cpu_addr);
            assign dma_word = byte_to_word(dma_addr);
        end else begin : g_param_map
            assign cpu_word = cpu_addr[ADDR_W+1:2];
            assign dma_word = dma_addr[ADDR_W+1:2];
        end
    endgenerate

    dmem_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk       (clk),
        .rst       (rst),
        .dma_req   (dma_req),
        .dma_gnt   (gnt_dma),
        .force_dma (force_dma)
    );

    // Same-cycle grant: CPU wins unless a starving DMA is being forced in.
    // Nothing is granted while reset is held, so the memory stays quiet.
    always_comb begin
        gnt_cpu = rst & cpu_req & ~(force_dma & dma_req);
        gnt_dma = rst & dma_req & ~gnt_cpu;
    end

    assign cpu_stall = rst & cpu_req & ~gnt_cpu;
    assign dma_gnt   = gnt_dma;
    assign mem_en    = gnt_cpu | gnt_dma;

    // Memory command mux from the winning requester; zeros when idle.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt_cpu) begin
            mem_we    = cpu_we;
            mem_addr  = cpu_word;
            mem_wdata = cpu_wdata;
        end else if (gnt_dma) begin
            mem_we    = dma_we;
            mem_addr  = dma_word;
            mem_wdata = dma_wdata;
        end
    end

    // Remember who issued this cycle's read so next cycle's data goes there.
    always_comb begin
        owner_d = OWN_NONE;
        if (gnt_cpu && !cpu_we) begin
            owner_d = OWN_CPU;
        end else if (gnt_dma && !dma_we) begin
            owner_d = OWN_DMA;
        end
    end

    // Read-owner register; reset drops any read still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    assign cpu_rvalid = (owner_q == OWN_CPU);
    assign dma_rvalid = (owner_q == OWN_DMA);
    assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
    assign dma_rdata  = dma_rvalid ? mem_rdata : '0;

endmodule
